// File: rtl/vram_fetch_scheduler_if.sv
// rtl/vram_fetch_scheduler_if.sv - CPU request/acknowledge bus into the VRAM fetch scheduler
interface vram_fetch_scheduler_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;

    // requester side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_wait
    );

    // scheduler side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_wait
    );
endinterface

// File: rtl/vram_fetch_scheduler.sv
// rtl/vram_fetch_scheduler.sv - VRAM port arbiter between display fetch and CPU
module vram_fetch_scheduler #(
    parameter int unsigned HACTIVE   = 256,
    parameter int unsigned VACTIVE   = 192,
    parameter logic [12:0] ATTR_BASE = 13'h1800
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [8:0]                   hcnt,
    input  logic [8:0]                   vcnt,
    vram_fetch_scheduler_if.slave        cpu,
    output logic [12:0]                  vram_addr,
    output logic                         vram_we,
    output logic [7:0]                   vram_dout,
    input  logic [7:0]                   vram_din,
    output logic [7:0]                   bitmap,
    output logic [7:0]                   attr,
    output logic                         pix_load
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RETURN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        active;
    logic        video_slot;
    logic        grant;
    logic        issue_we;
    logic [2:0]  slot;
    logic [12:0] bitmap_addr;
    logic [12:0] attr_addr;

    assign slot        = hcnt[2:0];
    assign active      = (32'(hcnt) < HACTIVE) && (32'(vcnt) < VACTIVE);
    // slots 0 and 1 of every active group belong to the display fetch
    assign video_slot  = active && (slot[2:1] == 2'b00);
    // bitmap layout interleaves character rows inside each third of the screen
    assign bitmap_addr = {vcnt[7:6], vcnt[2:0], vcnt[5:3], hcnt[7:3]};
    assign attr_addr   = ATTR_BASE + {3'b000, vcnt[7:3], hcnt[7:3]};
    assign vram_dout   = cpu.cpu_wdata;

    // arbiter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // grant decision, next state and RAM port mux; video always wins the port
    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        cpu.cpu_wait = 1'b0;
        vram_addr    = cpu.cpu_addr;
        vram_we      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu.cpu_req) begin
                    if (video_slot) begin
                        cpu.cpu_wait = 1'b1;
                    end else begin
                        grant     = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE:  state_nxt = S_RETURN;
            S_RETURN: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (video_slot) begin
            vram_addr = slot[0] ? attr_addr : bitmap_addr;
        end else if (grant && !rst) begin
            vram_we = cpu.cpu_we;
        end
    end

    // CPU completion, video byte capture and serializer load strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= 8'h00;
            issue_we      <= 1'b0;
            bitmap        <= 8'h00;
            attr          <= 8'h00;
            pix_load      <= 1'b0;
        end else begin
            cpu.cpu_ack <= (state == S_ISSUE);
            if (grant) begin
                issue_we <= cpu.cpu_we;
            end
            if ((state == S_ISSUE) && !issue_we) begin
                cpu.cpu_rdata <= vram_din;
            end
            if (active && (slot == 3'd1)) begin
                bitmap <= vram_din;
            end
            if (active && (slot == 3'd2)) begin
                attr <= vram_din;
            end
            pix_load <= active && (slot == 3'd6);
        end
    end

endmodule

// File: tb/tb_vram_fetch_scheduler.sv
// tb/tb_vram_fetch_scheduler.sv - self-checking bench for vram_fetch_scheduler
module tb_vram_fetch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  hcnt;
    logic [8:0]  vcnt;
    logic [12:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din;
    logic [7:0]  bitmap;
    logic [7:0]  attr;
    logic        pix_load;

    vram_fetch_scheduler_if cpu_bus();

    vram_fetch_scheduler #(
        .HACTIVE(256),
        .VACTIVE(192),
        .ATTR_BASE(13'h1800)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hcnt(hcnt),
        .vcnt(vcnt),
        .cpu(cpu_bus),
        .vram_addr(vram_addr),
        .vram_we(vram_we),
        .vram_dout(vram_dout),
        .vram_din(vram_din),
        .bitmap(bitmap),
        .attr(attr),
        .pix_load(pix_load)
    );

    always #5 clk = ~clk;

    // single-port synchronous RAM with a bench back door for preloading
    logic [7:0]  mem     [0:8191];
    logic [7:0]  ref_mem [0:8191];
    logic        tb_wr;
    logic [12:0] tb_wr_addr;
    logic [7:0]  tb_wr_data;

    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr] <= vram_dout;
        end else if (tb_wr) begin
            mem[tb_wr_addr] <= tb_wr_data;
        end
        vram_din <= mem[vram_addr];
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rdata;
    logic [7:0] exp_bitmap;
    logic [7:0] exp_attr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_free(input int h, input int v);
        return !((h < 256) && (v < 192) && ((h % 8) < 2));
    endfunction

    function automatic logic [12:0] baddr(input int v, input int g);
        return 13'(((v / 64) % 4) * 2048 + (v % 8) * 256 + ((v / 8) % 8) * 32 + g);
    endfunction

    function automatic logic [12:0] aaddr(input int v, input int g);
        return 13'(6144 + (v / 8) * 32 + g);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        hcnt            = 9'd300;
        vcnt            = 9'd300;
        cpu_bus.cpu_req = 1'b0;
        tb_wr           = 1'b1;
        tb_wr_addr      = a;
        tb_wr_data      = d;
        ref_mem[a]      = d;
        next_cycle();
        tb_wr = 1'b0;
    endtask

    task automatic run_group(input int v, input int g);
        for (int s = 0; s < 8; s++) begin
            hcnt = 9'(8 * g + s);
            vcnt = 9'(v);
            @(negedge clk);
            if (s == 0) chk("slot0_addr", 32'(vram_addr), 32'(baddr(v, g)));
            if (s == 1) chk("slot1_addr", 32'(vram_addr), 32'(aaddr(v, g)));
            if (s < 2)  chk("video_we", 32'(vram_we), 32'd0);
            if (s == 7) begin
                exp_bitmap = ref_mem[baddr(v, g)];
                exp_attr   = ref_mem[aaddr(v, g)];
                chk("bitmap", 32'(bitmap), 32'(exp_bitmap));
                chk("attr", 32'(attr), 32'(exp_attr));
                chk("pix_load_hi", 32'(pix_load), 32'd1);
            end else begin
                chk("pix_load_lo", 32'(pix_load), 32'd0);
            end
            next_cycle();
        end
    endtask

    task automatic border_group(input int h0, input int v);
        for (int s = 0; s < 8; s++) begin
            hcnt = 9'(h0 + s);
            vcnt = 9'(v);
            @(negedge clk);
            if (s == 7) begin
                chk("border_pix_load", 32'(pix_load), 32'd0);
                chk("border_bitmap", 32'(bitmap), 32'(exp_bitmap));
                chk("border_attr", 32'(attr), 32'(exp_attr));
            end
            next_cycle();
        end
    endtask

    task automatic cpu_txn(input bit we, input logic [12:0] a, input logic [7:0] wd,
                           input int h0, input int v);
        int gk;
        gk = 0;
        while (!is_free(h0 + gk, v) && gk < 8) gk++;
        if (!we) exp_rdata = ref_mem[a];
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wdata = wd;
        for (int k = 0; k <= gk + 2; k++) begin
            hcnt = 9'(h0 + k);
            vcnt = 9'(v);
            @(negedge clk);
            chk("cpu_wait", 32'(cpu_bus.cpu_wait), 32'(k < gk));
            chk("cpu_ack", 32'(cpu_bus.cpu_ack), 32'(k == gk + 2));
            if (k == gk) begin
                chk("grant_addr", 32'(vram_addr), 32'(a));
                chk("grant_we", 32'(vram_we), 32'(we));
            end else begin
                chk("nongrant_we", 32'(vram_we), 32'd0);
            end
            if (k == gk + 2) chk("cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'(exp_rdata));
            next_cycle();
        end
        cpu_bus.cpu_req = 1'b0;
        if (we) ref_mem[a] = wd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          v;
        int          g;
        int          h0;
        bit          we;
        logic [12:0] a;
        logic [7:0]  d;

        rst               = 1'b1;
        hcnt              = 9'd300;
        vcnt              = 9'd300;
        tb_wr             = 1'b0;
        tb_wr_addr        = 13'h0;
        tb_wr_data        = 8'h0;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = 13'h0055;
        cpu_bus.cpu_wdata = 8'hFF;
        exp_rdata         = 8'h00;
        exp_bitmap        = 8'h00;
        exp_attr          = 8'h00;

        // reset with a write request held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_vram_we", 32'(vram_we), 32'd0);
            chk("rst_cpu_ack", 32'(cpu_bus.cpu_ack), 32'd0);
            chk("rst_bitmap", 32'(bitmap), 32'd0);
            chk("rst_attr", 32'(attr), 32'd0);
            chk("rst_pix_load", 32'(pix_load), 32'd0);
            next_cycle();
        end
        rst             = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        next_cycle();

        // first group of the frame
        preload(13'h0000, 8'hAA);
        preload(13'h1800, 8'h38);
        run_group(0, 0);
        chk("first_bitmap_const", 32'(bitmap), 32'hAA);
        chk("first_attr_const", 32'(attr), 32'h38);

        // address mapping at v=65, h=40
        hcnt = 9'd40;
        vcnt = 9'd65;
        @(negedge clk);
        chk("map_slot0", 32'(vram_addr), 32'h0905);
        next_cycle();
        hcnt = 9'd41;
        @(negedge clk);
        chk("map_slot1", 32'(vram_addr), 32'h1905);
        next_cycle();

        // random groups
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 191));
            g = int'($urandom_range(0, 31));
            preload(baddr(v, g), 8'($urandom));
            preload(aaddr(v, g), 8'($urandom));
            run_group(v, g);
        end
        border_group(0, 200);
        border_group(256, 50);

        // CPU read blocked by the video slots, then the next fetch
        preload(13'h1234, 8'($urandom));
        preload(baddr(10, 2), 8'($urandom));
        preload(aaddr(10, 2), 8'($urandom));
        cpu_txn(1'b0, 13'h1234, 8'h00, 8, 10);
        for (int h = 13; h < 16; h++) begin
            hcnt = 9'(h);
            vcnt = 9'd10;
            next_cycle();
        end
        run_group(10, 2);

        // border write and read-back
        cpu_txn(1'b1, 13'h0100, 8'h5A, 20, 200);
        cpu_txn(1'b0, 13'h0100, 8'h00, 40, 200);
        chk("readback_const", 32'(cpu_bus.cpu_rdata), 32'h5A);

        // reset during the ISSUE cycle of a read
        preload(13'h0A0A, 8'($urandom));
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = 13'h0A0A;
        hcnt             = 9'd300;
        vcnt             = 9'd200;
        @(negedge clk);
        chk("pre_rst_wait", 32'(cpu_bus.cpu_wait), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", 32'(cpu_bus.cpu_ack), 32'd0);
        chk("mid_rst_we", 32'(vram_we), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("mid_rst_ack2", 32'(cpu_bus.cpu_ack), 32'd0);
        chk("mid_rst_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
        chk("mid_rst_bitmap", 32'(bitmap), 32'd0);
        next_cycle();
        rst             = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        exp_rdata       = 8'h00;
        exp_bitmap      = 8'h00;
        exp_attr        = 8'h00;
        @(negedge clk);
        chk("post_rst_ack", 32'(cpu_bus.cpu_ack), 32'd0);
        next_cycle();
        cpu_txn(1'b0, 13'h0A0A, 8'h00, 300, 200);
        border_group(0, 220);

        // random CPU traffic across active and border regions
        for (int i = 0; i < 16; i++) begin
            a  = 13'($urandom);
            we = 1'($urandom);
            d  = 8'($urandom);
            h0 = int'($urandom_range(0, 300));
            v  = int'($urandom_range(0, 250));
            if (!we) preload(a, 8'($urandom));
            cpu_txn(we, a, d, h0, v);
            if (we) begin
                h0 = int'($urandom_range(0, 300));
                v  = int'($urandom_range(0, 250));
                cpu_txn(1'b0, a, 8'h00, h0, v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
